state_decoder: RTL and testbench
================================

STATE_DECODER -- requirements
Module: state_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other ports are listed below.
REQ-002 The port clk SHALL be an input, 1 bit wide: the single clock; everything is sampled and updated on the rising edge.
REQ-003 The port res SHALL be an input, 1 bit wide: asynchronous active-low reset.
REQ-004 The port s SHALL be an input, 3 bits wide: observed state code of the 5-state sequence FSM (legal codes 2, 4, 1, 6, 7).
REQ-005 The port a_out SHALL be an output, 1 bit wide: the recovered FSM input bit.
REQ-006 The port a_valid SHALL be an output, 1 bit wide: a one-cycle pulse that qualifies a_out.
REQ-007 The port err SHALL be an output, 1 bit wide: a one-cycle pulse on an illegal code or an illegal transition while locked.
REQ-008 The port locked SHALL be an output, 1 bit wide: high while the block is in TRACK.
REQ-009 The port data SHALL be an output, 8 bits wide: the last assembled byte of recovered bits.
REQ-010 The port data_valid SHALL be an output, 1 bit wide: a one-cycle pulse when data is updated.
REQ-011 The port err_cnt SHALL be an output, 4 bits wide: a saturating error count (see Configuration).

Function
REQ-012 The block SHALL hold a 2-state machine, HUNT and TRACK, plus a 3-bit register prev holding the last accepted code.
REQ-013 In HUNT, on each edge: if s is legal, prev SHALL load s and the state SHALL go to TRACK; if s is illegal, the block SHALL stay in HUNT with no err.
REQ-014 In TRACK, each sampled pair (prev, s) SHALL be checked against this table:
  - 2->4, 1->6, 6->7: legal, no bit emitted.
  - 4->1: legal, bit 1.
  - 4->6: legal, bit 0.
  - 7->4: legal, bit 1.
  - 7->2: legal, bit 0.
REQ-015 On a legal TRACK pair, prev SHALL load s.
REQ-016 Every other pair SHALL be illegal, including a repeated code, since the FSM advances every cycle.
REQ-017 Codes 0, 3 and 5 SHALL be illegal in any state.
REQ-018 On an illegal pair in TRACK:
  - err SHALL pulse for one cycle.
  - The state SHALL go to HUNT.
  - The bit counter SHALL clear and the partial byte SHALL be discarded.
  - data SHALL keep its last value.
REQ-019 Outputs SHALL be registered: a_out/a_valid, err and data/data_valid SHALL appear in the cycle after the edge that sampled the deciding code (1-cycle latency).
REQ-020 locked SHALL reflect the state register.
REQ-021 a_out SHALL hold its last value when a_valid is low.
REQ-022 Recovered bits SHALL shift into the byte LSB-first: the first bit of a byte lands in data[0].
REQ-023 A 3-bit counter SHALL count emitted bits.
REQ-024 On the 8th bit, data SHALL load the full byte, data_valid SHALL pulse in the same cycle as that bit's a_valid, and the counter SHALL wrap to 0.
REQ-025 An error SHALL never coincide with a_valid, because an illegal pair emits no bit.

Reset
REQ-026 While res=0, the block SHALL be in the following state:
  - State HUNT, prev=0, counter=0.
  - a_out=0, a_valid=0, err=0, locked=0.
  - data=0x00, data_valid=0, err_cnt=0.
REQ-027 A reset asserted mid-byte SHALL discard the partial byte, and no data_valid SHALL be produced for it.
REQ-028 The first edge after res rises SHALL be treated as a HUNT sample.

Configuration
REQ-029 With STATE_DECODER_ERRCNT_EN defined, err_cnt SHALL increment on each err pulse, saturate at 15 (no wrap), and be updated in the same cycle as err.
REQ-030 Without STATE_DECODER_ERRCNT_EN, the err_cnt port SHALL remain and be tied to 0, and no counter logic SHALL be built.

Verification
REQ-031 The bench SHALL cover a zero path: reset, then s=2,4,6,7,2,4 -> a_valid pulses twice with a_out=0, err never high, locked high from the cycle after the first sample.
REQ-032 The bench SHALL cover a one path: s=2,4,1,6,7,4,1 -> three a_valid pulses, all a_out=1, no err.
REQ-033 The bench SHALL cover a byte: drive the sequence carrying bits 1,0,1,1,0,0,0,1 (first to last) -> data_valid pulses once with data=0x8D, coincident with the 8th a_valid.
REQ-034 The bench SHALL cover an illegal code and transition:
  - While locked, s=5 -> err pulses once, locked drops, err_cnt=1 (macro on) or 0 (macro off).
  - Then s=2,6 -> relock on 2, and 2->6 gives err, err_cnt=2.
REQ-035 The bench SHALL cover reset mid-byte: after 5 bits, pulse res=0 -> all outputs 0; next 8 bits produce exactly one data_valid with a byte made only of the new bits.
REQ-036 The bench SHALL cover saturation: 17 illegal events with the macro on -> err_cnt stops at 15, and 17 err pulses are observed.

Source files
------------

// File: rtl/state_decoder_if.sv
// state_decoder_if -- bundle between an FSM state observer and its consumer.
//
// Signals:
//   s          [2:0] observed state code of the 5-state sequence FSM
//   a_out            recovered FSM input bit (holds its value between pulses)
//   a_valid          one-cycle pulse qualifying a_out
//   err              one-cycle pulse on an illegal code or illegal transition
//   locked           high while the decoder is tracking the sequence
//   data       [7:0] last assembled byte of recovered bits (LSB first)
//   data_valid       one-cycle pulse when data is updated
//   err_cnt    [3:0] saturating error count (0 when the counter is not built)
//
// Handshake: there is no back-pressure. Every *_valid / err output is a
// single-cycle pulse that qualifies its payload in the cycle it is high; the
// consumer must sample on that cycle, and the payload holds its last value
// afterwards.
//
// Modports: master drives s and observes the results; slave is the decoder.
interface state_decoder_if;
    logic [2:0] s;
    logic       a_out;
    logic       a_valid;
    logic       err;
    logic       locked;
    logic [7:0] data;
    logic       data_valid;
    logic [3:0] err_cnt;

    modport master (
        output s,
        input  a_out, a_valid, err, locked, data, data_valid, err_cnt
    );

    modport slave (
        input  s,
        output a_out, a_valid, err, locked, data, data_valid, err_cnt
    );
endinterface

// File: rtl/state_decoder.sv
// state_decoder -- recovers the input bit stream of a 5-state sequence FSM
// from its observed state codes, and packs the bits into bytes.
//
// The observed FSM walks codes 2,4,1,6,7. Only transitions leaving 4 or 7
// depend on the FSM input, so those are the only ones that yield a bit:
//   2->4, 1->6, 6->7 : no bit      4->1 : 1    4->6 : 0
//   7->4 : 1         7->2 : 0      anything else (incl. repeats) : illegal
//
// The decoder HUNTs for any legal code to lock on, then TRACKs pairs of
// consecutive codes. An illegal pair drops back to HUNT, pulses err and
// discards the partially assembled byte.
//
// Ports:
//   clk   clock, rising edge
//   res   asynchronous active-low reset
//   bus   state_decoder_if.slave (s in; a_out, a_valid, err, locked, data,
//         data_valid, err_cnt out). All outputs are registered.
//
// Build option: define STATE_DECODER_ERRCNT_EN to build the 4-bit
// saturating error counter; otherwise err_cnt is tied to 0.
module state_decoder (
    input  logic                  clk,
    input  logic                  res,
    state_decoder_if.slave        bus
);

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] prev;
    logic [2:0] cnt;
    logic [6:0] partial;     // bits 0..6 of the byte being assembled
    logic       a_out_q;
    logic       a_valid_q;
    logic       err_q;
    logic [7:0] data_q;
    logic       data_valid_q;

    // Pair decode
    logic code_legal;
    logic pair_ok;
    logic bit_en;
    logic bit_val;
    logic pair_err;

    always_comb begin
        code_legal = 1'b0;
        pair_ok    = 1'b0;
        bit_en     = 1'b0;
        bit_val    = 1'b0;
        case (bus.s)
            3'd1, 3'd2, 3'd4, 3'd6, 3'd7: code_legal = 1'b1;
            default:                      code_legal = 1'b0;
        endcase
        // Octal literal: first digit is prev, second is the new code.
        case ({prev, bus.s})
            6'o24, 6'o16, 6'o67: pair_ok = 1'b1;
            6'o41: begin pair_ok = 1'b1; bit_en = 1'b1; bit_val = 1'b1; end
            6'o46: begin pair_ok = 1'b1; bit_en = 1'b1; bit_val = 1'b0; end
            6'o74: begin pair_ok = 1'b1; bit_en = 1'b1; bit_val = 1'b1; end
            6'o72: begin pair_ok = 1'b1; bit_en = 1'b1; bit_val = 1'b0; end
            default: begin
                pair_ok = 1'b0;
                bit_en  = 1'b0;
                bit_val = 1'b0;
            end
        endcase
        pair_err = (state == TRACK) && !pair_ok;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state        <= HUNT;
            prev         <= 3'd0;
            cnt          <= 3'd0;
            partial      <= 7'd0;
            a_out_q      <= 1'b0;
            a_valid_q    <= 1'b0;
            err_q        <= 1'b0;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
        end else begin
            // Pulses default low every cycle.
            a_valid_q    <= 1'b0;
            err_q        <= 1'b0;
            data_valid_q <= 1'b0;
            case (state)
                HUNT: begin
                    // Illegal codes are simply ignored while hunting.
                    if (code_legal) begin
                        prev  <= bus.s;
                        state <= TRACK;
                    end
                end
                TRACK: begin
                    if (pair_ok) begin
                        prev <= bus.s;
                        if (bit_en) begin
                            a_valid_q <= 1'b1;
                            a_out_q   <= bit_val;
                            if (cnt == 3'd7) begin
                                // 8th bit completes the byte; it goes straight
                                // into the MSB without passing through partial.
                                data_q       <= {bit_val, partial};
                                data_valid_q <= 1'b1;
                                cnt          <= 3'd0;
                            end else begin
                                partial[cnt] <= bit_val;
                                cnt          <= cnt + 3'd1;
                            end
                        end
                    end else begin
                        // Clearing cnt is enough to discard the partial byte:
                        // every position is rewritten before it is used again.
                        err_q <= 1'b1;
                        state <= HUNT;
                        cnt   <= 3'd0;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

`ifdef STATE_DECODER_ERRCNT_EN
    logic [3:0] err_cnt_q;

    // Counts on the same edge that raises err, so both appear together.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            err_cnt_q <= 4'd0;
        end else if (pair_err && (err_cnt_q != 4'd15)) begin
            err_cnt_q <= err_cnt_q + 4'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 4'd0;
`endif

    assign bus.a_out      = a_out_q;
    assign bus.a_valid    = a_valid_q;
    assign bus.err        = err_q;
    assign bus.locked     = (state == TRACK);
    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;

endmodule

// File: tb/tb_state_decoder.sv
// tb_state_decoder -- directed and randomized bench for state_decoder.
// A transition-table reference model predicts every output each cycle;
// completed bytes are also queued and matched against data on data_valid.
module tb_state_decoder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    state_decoder_if bus_if();

    state_decoder dut (
        .clk (clk),
        .res (res),
        .bus (bus_if)
    );

`ifdef STATE_DECODER_ERRCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    // ---------------- counters ----------------
    int n_vec  = 0;
    int n_miss = 0;
    int n_chk  = 0;
    int pulses_av, pulses_dv, pulses_err, ones_seen;

    // ---------------- reference model ----------------
    // Legal transitions: from, to, emitted bit (-1 = none).
    int t_from[7] = '{2, 1, 6, 4, 4, 7, 7};
    int t_to[7]   = '{4, 6, 7, 1, 6, 4, 2};
    int t_bit[7]  = '{-1, -1, -1, 1, 0, 1, 0};

    bit         m_locked;
    int         m_prev;
    bit         m_a_out, m_a_valid, m_err, m_data_valid;
    logic [7:0] m_data;
    int         m_errcnt;
    bit         m_bits[$];
    logic [7:0] exp_q[$];

    int zero_path[6] = '{2, 4, 6, 7, 2, 4};
    int one_path[7]  = '{2, 4, 1, 6, 7, 4, 1};
    int byte_bits[8] = '{1, 0, 1, 1, 0, 0, 0, 1};

    function automatic int lookup(int p, int c);
        foreach (t_from[i])
            if (t_from[i] == p && t_to[i] == c) return t_bit[i];
        return -2;
    endfunction

    function automatic int succ(int p, int b);
        foreach (t_from[i])
            if (t_from[i] == p && t_bit[i] == b) return t_to[i];
        return -1;
    endfunction

    function automatic bit is_code(int c);
        return (c == 1) || (c == 2) || (c == 4) || (c == 6) || (c == 7);
    endfunction

    task automatic model_reset();
        m_locked = 0; m_prev = 0;
        m_a_out = 0; m_a_valid = 0; m_err = 0; m_data_valid = 0;
        m_data = 8'h00; m_errcnt = 0;
        m_bits.delete();
        exp_q.delete();
    endtask

    task automatic model_step(int c);
        int r;
        m_a_valid = 0; m_err = 0; m_data_valid = 0;
        if (!m_locked) begin
            if (is_code(c)) begin
                m_prev = c;
                m_locked = 1;
            end
        end else begin
            r = lookup(m_prev, c);
            if (r == -2) begin
                m_err = 1;
                m_locked = 0;
                m_bits.delete();
                if (CNT_ON && m_errcnt < 15) m_errcnt++;
            end else begin
                m_prev = c;
                if (r >= 0) begin
                    m_a_valid = 1;
                    m_a_out = r[0];
                    m_bits.push_back(r[0]);
                    if (m_bits.size() == 8) begin
                        for (int i = 0; i < 8; i++) m_data[i] = m_bits[i];
                        m_data_valid = 1;
                        exp_q.push_back(m_data);
                        m_bits.delete();
                    end
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(string tag);
        logic [7:0] e;
        chk({tag, ".a_out"},      32'(bus_if.a_out),      32'(m_a_out));
        chk({tag, ".a_valid"},    32'(bus_if.a_valid),    32'(m_a_valid));
        chk({tag, ".err"},        32'(bus_if.err),        32'(m_err));
        chk({tag, ".locked"},     32'(bus_if.locked),     32'(m_locked));
        chk({tag, ".data"},       32'(bus_if.data),       32'(m_data));
        chk({tag, ".data_valid"}, 32'(bus_if.data_valid), 32'(m_data_valid));
        chk({tag, ".err_cnt"},    32'(bus_if.err_cnt),    32'(m_errcnt));
        if (bus_if.data_valid === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            chk({tag, ".sb_byte"}, 32'(bus_if.data), 32'(e));
        end
        if (bus_if.a_valid === 1'b1) pulses_av++;
        if (bus_if.data_valid === 1'b1) pulses_dv++;
        if (bus_if.err === 1'b1) pulses_err++;
        if (bus_if.a_valid === 1'b1 && bus_if.a_out === 1'b1) ones_seen++;
    endtask

    task automatic clear_counts();
        pulses_av = 0; pulses_dv = 0; pulses_err = 0; ones_seen = 0;
    endtask

    // ---------------- drivers ----------------
    task automatic apply(int c, string tag);
        bus_if.s = c[2:0];
        @(posedge clk);
        #1;
        n_vec++;
        model_step(c);
        check_outputs(tag);
    endtask

    task automatic do_reset(string tag);
        res = 1'b0;
        #2;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        res = 1'b1;
    endtask

    // Walk the no-bit transitions until the requested bit can be emitted.
    task automatic emit_bit(int b, string tag);
        int n;
        n = succ(m_prev, b);
        for (int k = 0; k < 4 && n < 0; k++) begin
            apply(succ(m_prev, -1), tag);
            n = succ(m_prev, b);
        end
        apply(n, tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         nb;
        logic [7:0] new_byte;
        int         cand[$];
        int         c;

        res = 1'b0;
        bus_if.s = 3'd0;
        clear_counts();
        #1;
        do_reset("reset");

        // Zero path: two 0-bits, no errors, locked after the first sample.
        clear_counts();
        foreach (zero_path[i]) begin
            apply(zero_path[i], "zero");
            if (i == 0) chk("zero.locked_first", 32'(bus_if.locked), 32'd1);
        end
        chk("zero.av_pulses", 32'(pulses_av), 32'd2);
        chk("zero.ones", 32'(ones_seen), 32'd0);
        chk("zero.err_pulses", 32'(pulses_err), 32'd0);

        // One path: three 1-bits.
        do_reset("reset_one");
        clear_counts();
        foreach (one_path[i]) apply(one_path[i], "one");
        chk("one.av_pulses", 32'(pulses_av), 32'd3);
        chk("one.ones", 32'(ones_seen), 32'd3);
        chk("one.err_pulses", 32'(pulses_err), 32'd0);

        // Full byte 1,0,1,1,0,0,0,1 -> 0x8D.
        do_reset("reset_byte");
        clear_counts();
        apply(2, "byte");
        foreach (byte_bits[i]) emit_bit(byte_bits[i], "byte");
        chk("byte.data", 32'(bus_if.data), 32'h8D);
        chk("byte.dv_with_av", 32'({bus_if.data_valid, bus_if.a_valid}), 32'b11);
        chk("byte.dv_pulses", 32'(pulses_dv), 32'd1);

        // Illegal code while locked, then relock and illegal transition.
        clear_counts();
        apply(5, "illegal_code");
        chk("ill.err", 32'(bus_if.err), 32'd1);
        chk("ill.locked", 32'(bus_if.locked), 32'd0);
        chk("ill.err_cnt1", 32'(bus_if.err_cnt), CNT_ON ? 32'd1 : 32'd0);
        apply(2, "relock");
        chk("ill.relock", 32'(bus_if.locked), 32'd1);
        apply(6, "illegal_pair");
        chk("ill.err2", 32'(bus_if.err), 32'd1);
        chk("ill.err_cnt2", 32'(bus_if.err_cnt), CNT_ON ? 32'd2 : 32'd0);
        chk("ill.err_pulses", 32'(pulses_err), 32'd2);

        // Reset mid-byte: partial byte must vanish.
        do_reset("reset_mid_a");
        apply(2, "mid_pre");
        for (int i = 0; i < 5; i++) emit_bit(int'($urandom_range(0, 1)), "mid_pre");
        do_reset("reset_mid");
        chk("mid.data_zero", 32'(bus_if.data), 32'd0);
        clear_counts();
        apply(2, "mid_post");
        for (int i = 0; i < 8; i++) begin
            nb = int'($urandom_range(0, 1));
            new_byte[i] = nb[0];
            emit_bit(nb, "mid_post");
        end
        chk("mid.dv_pulses", 32'(pulses_dv), 32'd1);
        chk("mid.byte", 32'(bus_if.data), 32'(new_byte));

        // Randomized walk with occasional garbage codes.
        do_reset("reset_rand");
        for (int i = 0; i < 600; i++) begin
            cand.delete();
            foreach (t_from[k]) if (t_from[k] == m_prev) cand.push_back(t_to[k]);
            if (!m_locked || cand.size() == 0 || $urandom_range(0, 9) == 0)
                c = int'($urandom_range(0, 7));
            else
                c = cand[$urandom_range(0, cand.size() - 1)];
            apply(c, "rand");
        end

        // Saturation: 17 illegal events.
        do_reset("reset_sat");
        clear_counts();
        for (int i = 0; i < 17; i++) begin
            apply(2, "sat");
            apply(5, "sat");
        end
        chk("sat.err_pulses", 32'(pulses_err), 32'd17);
        chk("sat.err_cnt", 32'(bus_if.err_cnt), CNT_ON ? 32'd15 : 32'd0);

        chk("sb.leftover", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
